// File: rtl/seg7_decoder.sv
// Seven-segment (active-low) to hex decoder with input debounce and a valid/ready output hold.
// Optional 8-bit saturating error counter enabled by defining SEG7_DECODER_ERRCNT_EN.
module seg7_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hex_in,
  input  logic       dout_ready,
  output logic [3:0] dout,
  output logic       dout_err,
  output logic       dout_valid
`ifdef SEG7_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic {TRACK = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [6:0] BLANK   = 7'b1111111;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] last_q, last_d;
  logic [3:0] dout_q, dout_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic [3:0] glyph_val;
  logic       glyph_ok;
  logic       qualify;

  always_comb begin
    glyph_val = 4'h0;
    glyph_ok  = 1'b1;
    case (cand_q)
      7'b1000000: glyph_val = 4'h0;
      7'b1111001: glyph_val = 4'h1;
      7'b0100100: glyph_val = 4'h2;
      7'b0110000: glyph_val = 4'h3;
      7'b0011001: glyph_val = 4'h4;
      7'b0010010: glyph_val = 4'h5;
      7'b0000010: glyph_val = 4'h6;
      7'b1111000: glyph_val = 4'h7;
      7'b0000000: glyph_val = 4'h8;
      7'b0010000: glyph_val = 4'h9;
      7'b0001000: glyph_val = 4'hA;
      7'b0000011: glyph_val = 4'hB;
      7'b1000110: glyph_val = 4'hC;
      7'b0100001: glyph_val = 4'hD;
      7'b0000110: glyph_val = 4'hE;
      7'b0001110: glyph_val = 4'hF;
      default:    glyph_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    dout_d    = dout_q;
    err_d     = err_q;
    valid_d   = valid_q;
    err_cnt_d = err_cnt_q;
    qualify   = 1'b0;
    case (state_q)
      TRACK: begin
        if (hex_in == cand_q) begin
          if (cnt_q == CNT_MAX) qualify = 1'b1;
          else                  cnt_d   = cnt_q + 8'd1;
        end else begin
          cand_d = hex_in;
          cnt_d  = 8'd0;
        end
        // A repeat of the last emitted glyph is suppressed; blank only re-arms it.
        if (qualify && (cand_q != last_q)) begin
          last_d = cand_q;
          if (cand_q != BLANK) begin
            dout_d  = glyph_val;
            err_d   = ~glyph_ok;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (dout_ready) begin
          valid_d = 1'b0;
          state_d = TRACK;
          cnt_d   = 8'd0;
          cand_d  = hex_in;
          if (err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = TRACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TRACK;
      cand_q    <= BLANK;
      cnt_q     <= 8'd0;
      last_q    <= BLANK;
      dout_q    <= 4'h0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_err   = err_q;
  assign dout_valid = valid_q;

`ifdef SEG7_DECODER_ERRCNT_EN
  assign err_cnt = err_cnt_q;
`else
  logic unused_err_cnt;
  assign unused_err_cnt = ^err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_decoder.sv
// Randomised and directed bench for seg7_decoder against a run-length reference model.
module tb_seg7_decoder;

  localparam int S = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] hex_in = BLANK;
  logic       dout_ready = 1'b0;
  logic [3:0] dout;
  logic       dout_err;
  logic       dout_valid;
`ifdef SEG7_DECODER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  seg7_decoder #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hex_in     (hex_in),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_err   (dout_err),
    .dout_valid (dout_valid)
`ifdef SEG7_DECODER_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a pattern is accepted once it has been seen on S+1 consecutive edges.
  logic [6:0] m_cur;
  int         m_run;
  logic [6:0] m_last;
  logic       m_busy;
  logic [3:0] m_dout;
  logic       m_err;
  logic       m_valid;
  int         m_errcnt;

  task automatic model_reset();
    m_cur = BLANK; m_run = 1; m_last = BLANK; m_busy = 1'b0;
    m_dout = 4'h0; m_err = 1'b0; m_valid = 1'b0; m_errcnt = 0;
  endtask

  task automatic model_edge(input logic [6:0] h, input logic rdy);
    int idx;
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      if (rdy) begin
        if (m_err && m_errcnt < 255) m_errcnt++;
        m_busy = 1'b0; m_valid = 1'b0; m_cur = h; m_run = 1;
      end
    end else begin
      if (h == m_cur) m_run++;
      else begin m_cur = h; m_run = 1; end
      if (m_run >= S + 1 && m_cur != m_last) begin
        m_last = m_cur;
        if (m_cur != BLANK) begin
          idx = -1;
          for (int k = 0; k < 16; k++) if (GLYPH[k] == m_cur) idx = k;
          m_err   = (idx < 0);
          m_dout  = (idx < 0) ? 4'h0 : 4'(idx);
          m_valid = 1'b1;
          m_busy  = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(hex_in, dout_ready);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hex_in = BLANK; dout_ready = 1'b0;
    model_reset();
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    checks++;
    if (dout !== 4'h0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    checks++;
    if (dout_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", dout_err); end
    $display("reset: valid=%b dout=%h err=%b", dout_valid, dout, dout_err);
  endtask

  task automatic test_latency();
    int first = 0;
    int pulses = 0;
    do_reset();
    hex_in = 7'b0100100; dout_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if ({dout_valid, dout_err, dout} !== {m_valid, m_err, m_dout}) begin
        errors++;
        $display("FAIL latency_cycle%0d got v%b e%b d%h want v%b e%b d%h", i, dout_valid, dout_err, dout, m_valid, m_err, m_dout);
      end
      if (dout_valid) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    checks++;
    if (first != S + 1) begin errors++; $display("FAIL latency_edge got %0d want %0d", first, S + 1); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL latency_pulses got %0d want 1", pulses); end
    $display("latency: first valid after edge %0d, pulses %0d", first, pulses);
  endtask

  task automatic test_toggle();
    int pulses = 0;
    logic [3:0] seen = 4'h0;
    dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hex_in = ((i / 2) % 2 == 0) ? 7'b0000010 : 7'b0000000;
      tick();
      if (dout_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL toggle_novalid got %0d pulses want 0", pulses); end
    hex_in = 7'b0000000;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({dout_valid, dout_err, dout} !== {m_valid, m_err, m_dout}) begin
        errors++;
        $display("FAIL toggle_model got v%b e%b d%h want v%b e%b d%h", dout_valid, dout_err, dout, m_valid, m_err, m_dout);
      end
      if (dout_valid) begin pulses++; seen = dout; end
    end
    checks++;
    if (pulses != 1 || seen !== 4'h8) begin errors++; $display("FAIL toggle_digit got %0d pulses d%h want 1 pulse d8", pulses, seen); end
    $display("toggle: pulses after hold %0d digit %h", pulses, seen);
  endtask

  task automatic test_illegal();
    int got = 0;
    dout_ready = 1'b0; hex_in = 7'b1010101;
    for (int i = 0; i < 10 && !dout_valid; i++) tick();
    checks++;
    if (!(dout_valid === 1'b1 && dout === 4'h0 && dout_err === 1'b1)) begin
      errors++; $display("FAIL illegal got v%b d%h e%b want v1 d0 e1", dout_valid, dout, dout_err);
    end
    dout_ready = 1'b1;
    tick();
`ifdef SEG7_DECODER_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'(m_errcnt)) begin errors++; $display("FAIL illegal_errcnt got %0d want %0d", err_cnt, m_errcnt); end
    got = int'(err_cnt);
`endif
    $display("illegal: d%h e%b cnt %0d", dout, dout_err, got);
  endtask

  task automatic test_hold();
    int bad = 0;
    dout_ready = 1'b0; hex_in = 7'b0010010;
    for (int i = 0; i < 10 && !dout_valid; i++) tick();
    hex_in = 7'b1111001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(dout_valid === 1'b1 && dout === 4'h5 && dout_err === 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    dout_ready = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL hold_release got v%b want 0", dout_valid); end
    for (int i = 0; i < S; i++) tick();
    checks++;
    if (!(dout_valid === 1'b1 && dout === 4'h1)) begin errors++; $display("FAIL hold_next got v%b d%h want v1 d1", dout_valid, dout); end
    $display("hold: released, next digit %h valid %b", dout, dout_valid);
    tick();
  endtask

  task automatic test_blank_seq();
    int sevens = 0;
    logic [6:0] seq [3] = '{7'b1111000, BLANK, 7'b1111000};
    dout_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      hex_in = seq[p];
      for (int i = 0; i < 6; i++) begin
        tick();
        checks++;
        if ({dout_valid, dout_err, dout} !== {m_valid, m_err, m_dout}) begin
          errors++;
          $display("FAIL blank_model got v%b e%b d%h want v%b e%b d%h", dout_valid, dout_err, dout, m_valid, m_err, m_dout);
        end
        if (dout_valid && dout === 4'h7) sevens++;
      end
    end
    checks++;
    if (sevens != 2) begin errors++; $display("FAIL blank_seq got %0d sevens want 2", sevens); end
    $display("blank: transactions of 7 = %0d", sevens);
  endtask

  task automatic test_reset_hold();
    dout_ready = 1'b0; hex_in = 7'b0110000;
    for (int i = 0; i < 10 && !dout_valid; i++) tick();
    checks++;
    if (dout_valid !== 1'b1) begin errors++; $display("FAIL rsthold_enter got v%b want 1", dout_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL rsthold_async got v%b want 0", dout_valid); end
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10 && !dout_valid; i++) tick();
    checks++;
    if (!(dout_valid === 1'b1 && dout === 4'h3)) begin errors++; $display("FAIL rsthold_reemit got v%b d%h want v1 d3", dout_valid, dout); end
    $display("reset_hold: re-emitted %h", dout);
    dout_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int left = 0;
    int txns = 0;
    int r;
    for (int i = 0; i < 600; i++) begin
      if (left == 0) begin
        r = $urandom_range(0, 17);
        if (r < 16)       hex_in = GLYPH[r];
        else if (r == 16) hex_in = BLANK;
        else              hex_in = 7'($urandom);
        left = $urandom_range(1, 8);
      end
      left--;
      dout_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if ({dout_valid, dout_err, dout} !== {m_valid, m_err, m_dout}) begin
        errors++;
        $display("FAIL random_cycle%0d got v%b e%b d%h want v%b e%b d%h", i, dout_valid, dout_err, dout, m_valid, m_err, m_dout);
      end
`ifdef SEG7_DECODER_ERRCNT_EN
      checks++;
      if (err_cnt !== 8'(m_errcnt)) begin errors++; $display("FAIL random_errcnt got %0d want %0d", err_cnt, m_errcnt); end
`endif
      if (dout_valid && dout_ready) txns++;
    end
    $display("random: %0d handshakes over 600 cycles", txns);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_toggle();
    test_illegal();
    test_hold();
    test_blank_seq();
    test_reset_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
